// File: rtl/rr_arb8.sv
// rr_arb8: 8-requester round-robin arbiter with registered grant/select held for a whole burst.
// Optional beat-count burst limit enabled by defining ARB_BURST_LIMIT_EN.

module rr_arb8_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] grant,
  input logic [2:0] sel,
  input logic       gnt_valid,
  input logic       owner_last
);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));

  a_grant_matches_sel: assert property (@(posedge clk) disable iff (!rst_n)
    grant[sel] == gnt_valid);

  a_last_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    owner_last |-> gnt_valid);

endmodule

module rr_arb8 #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       beat,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       gnt_valid,
  output logic       owner_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // {found, index}: first requester at or after start_v, wrapping modulo 8.
  function automatic logic [3:0] pick_winner(input logic [7:0] req_v, input logic [2:0] start_v);
    logic [3:0] res_v;
    logic [2:0] idx_v;
    res_v = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx_v = start_v + 3'(k);
      res_v = req_v[idx_v] ? {1'b1, idx_v} : res_v;
    end
    return res_v;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx_v);
    return 8'h01 << idx_v;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [3:0] idle_win_s;
  logic [3:0] next_win_s;

  assign idle_win_s = pick_winner(req, ptr_q);
  // Searching from sel+1 covers both a release (owner bit already clear) and a forced re-arbitration.
  assign next_win_s = pick_winner(req, sel_q + 3'd1);

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_last_q, owner_last_d;
`endif

  // Next-state: arbitration, burst hold and hand-off.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (idle_win_s[3]) begin
          state_d     = BUSY;
          grant_d     = onehot8(idle_win_s[2:0]);
          sel_d       = idle_win_s[2:0];
          gnt_valid_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
          cnt_d       = '0;
`endif
        end else begin
          grant_d     = 8'h00;
          gnt_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (!req[sel_q]) begin
          ptr_d = sel_q + 3'd1;
          if (next_win_s[3]) begin
            grant_d     = onehot8(next_win_s[2:0]);
            sel_d       = next_win_s[2:0];
            gnt_valid_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d     = IDLE;
            grant_d     = 8'h00;
            gnt_valid_d = 1'b0;
          end
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (beat && owner_last_q) begin
          // Owner still requests, so the search always finds someone (possibly the owner itself).
          ptr_d       = sel_q + 3'd1;
          grant_d     = onehot8(next_win_s[2:0]);
          sel_d       = next_win_s[2:0];
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        else begin
          grant_d = grant_q;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = 8'h00;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

`ifdef ARB_BURST_LIMIT_EN
  assign owner_last_d = gnt_valid_d && (cnt_d == LAST_CNT);

  // Beat counter and registered last-beat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      owner_last_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      owner_last_q <= owner_last_d;
    end
  end

  assign owner_last = owner_last_q;
`else
  logic unused_s;
  assign unused_s   = ^{beat, CNT_W'(MAX_BURST)};
  assign owner_last = 1'b0;
`endif

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 8'h00;
      sel_q       <= 3'd0;
      ptr_q       <= 3'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;

  rr_arb8_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .grant      (grant_q),
    .sel        (sel_q),
    .gnt_valid  (gnt_valid_q),
    .owner_last (owner_last)
  );

endmodule

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 (burst-limit checks built when ARB_BURST_LIMIT_EN is defined).

module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       beat;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       owner_last;

  int n_cmp;
  int n_err;

  rr_arb8 #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .beat       (beat),
    .grant      (grant),
    .sel        (sel),
    .gnt_valid  (gnt_valid),
    .owner_last (owner_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    beat  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    beat  = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant !== 8'h00) begin n_err++; $display("FAIL reset_grant: got %h exp %h", grant, 8'h00); end
    n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d exp %0d", sel, 3'd0); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp %b", gnt_valid, 1'b0); end
    n_cmp++; if (owner_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b exp %b", owner_last, 1'b0); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (grant !== 8'h01) begin n_err++; $display("FAIL first_grant: got %h exp %h", grant, 8'h01); end
    n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL first_sel: got %0d exp %0d", sel, 3'd0); end
    n_cmp++; if (gnt_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b exp %b", gnt_valid, 1'b1); end
  endtask

  task automatic test_handoff();
    req = 8'b1000_0100;
    tick();
    n_cmp++; if (grant !== 8'h04) begin n_err++; $display("FAIL handoff2_grant: got %h exp %h", grant, 8'h04); end
    n_cmp++; if (sel !== 3'd2) begin n_err++; $display("FAIL handoff2_sel: got %0d exp %0d", sel, 3'd2); end
    n_cmp++; if (gnt_valid !== 1'b1) begin n_err++; $display("FAIL handoff2_valid: got %b exp %b", gnt_valid, 1'b1); end
    req = 8'b1000_0000;
    tick();
    n_cmp++; if (sel !== 3'd7) begin n_err++; $display("FAIL handoff7_sel: got %0d exp %0d", sel, 3'd7); end
    n_cmp++; if (grant !== 8'h80) begin n_err++; $display("FAIL handoff7_grant: got %h exp %h", grant, 8'h80); end
    req = 8'h00;
    tick();
    n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b exp %b", gnt_valid, 1'b0); end
    n_cmp++; if (grant !== 8'h00) begin n_err++; $display("FAIL idle_grant: got %h exp %h", grant, 8'h00); end
    n_cmp++; if (sel !== 3'd7) begin n_err++; $display("FAIL idle_sel_hold: got %0d exp %0d", sel, 3'd7); end
  endtask

  task automatic test_wrap();
    req = 8'b1000_0010;
    tick();
    n_cmp++; if (grant !== 8'h02) begin n_err++; $display("FAIL wrap_grant: got %h exp %h", grant, 8'h02); end
    n_cmp++; if (sel !== 3'd1) begin n_err++; $display("FAIL wrap_sel: got %0d exp %0d", sel, 3'd1); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 8'b0000_1000;
    tick();
    n_cmp++; if (sel !== 3'd3) begin n_err++; $display("FAIL hold_start_sel: got %0d exp %0d", sel, 3'd3); end
    req  = 8'b0000_1011;
    beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (grant !== 8'h08) begin n_err++; $display("FAIL hold_grant[%0d]: got %h exp %h", i, grant, 8'h08); end
    end
    beat = 1'b0;
    // Owner 3 releases; search starts at 4 and wraps to 0.
    req = 8'b0000_0011;
    tick();
    n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL hold_release_sel: got %0d exp %0d", sel, 3'd0); end
    // Owner 0 drops for one cycle then re-requests: 1 wins, and 0 ranks last afterwards.
    req = 8'b0000_0010;
    tick();
    req = 8'b0000_0101;
    tick();
    n_cmp++; if (sel !== 3'd2) begin n_err++; $display("FAIL recompete_sel: got %0d exp %0d", sel, 3'd2); end
  endtask

  task automatic test_fairness();
    int exp_sel;
    do_reset();
    req = 8'hFF;
    tick();
    exp_sel = 0;
    for (int g = 0; g < 9; g++) begin
      n_cmp++; if (sel !== 3'(exp_sel)) begin n_err++; $display("FAIL fair_first[%0d]: got %0d exp %0d", g, sel, exp_sel); end
      tick();
      n_cmp++; if (sel !== 3'(exp_sel)) begin n_err++; $display("FAIL fair_hold[%0d]: got %0d exp %0d", g, sel, exp_sel); end
      req = 8'hFF & ~(8'h01 << exp_sel);
      tick();
      req = 8'hFF;
      exp_sel = (exp_sel + 1) % 8;
      n_cmp++; if (gnt_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d]: got %b exp %b", g, gnt_valid, 1'b1); end
    end
  endtask

`ifdef ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    do_reset();
    req = 8'b0010_1000;
    tick();
    n_cmp++; if (sel !== 3'd3) begin n_err++; $display("FAIL lim_start_sel: got %0d exp %0d", sel, 3'd3); end
    beat = 1'b1;
    tick();
    tick();
    n_cmp++; if (owner_last !== 1'b0) begin n_err++; $display("FAIL lim_early_last: got %b exp %b", owner_last, 1'b0); end
    tick();
    n_cmp++; if (owner_last !== 1'b1) begin n_err++; $display("FAIL lim_last: got %b exp %b", owner_last, 1'b1); end
    tick();
    n_cmp++; if (sel !== 3'd5) begin n_err++; $display("FAIL lim_move_sel: got %0d exp %0d", sel, 3'd5); end
    n_cmp++; if (owner_last !== 1'b0) begin n_err++; $display("FAIL lim_move_last: got %b exp %b", owner_last, 1'b0); end
    beat = 1'b0;

    do_reset();
    req = 8'b0000_1000;
    tick();
    beat = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (owner_last !== 1'b1) begin n_err++; $display("FAIL solo_last: got %b exp %b", owner_last, 1'b1); end
    tick();
    n_cmp++; if (sel !== 3'd3) begin n_err++; $display("FAIL solo_sel: got %0d exp %0d", sel, 3'd3); end
    n_cmp++; if (gnt_valid !== 1'b1) begin n_err++; $display("FAIL solo_valid: got %b exp %b", gnt_valid, 1'b1); end
    n_cmp++; if (owner_last !== 1'b0) begin n_err++; $display("FAIL solo_restart: got %b exp %b", owner_last, 1'b0); end
    tick();
    n_cmp++; if (owner_last !== 1'b0) begin n_err++; $display("FAIL solo_cnt1: got %b exp %b", owner_last, 1'b0); end
    beat = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    req = 8'b0010_0000;
    tick();
    n_cmp++; if (sel !== 3'd5) begin n_err++; $display("FAIL arst_setup_sel: got %0d exp %0d", sel, 3'd5); end
    beat = 1'b1;
    tick();
    tick();
    beat  = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 8'h00) begin n_err++; $display("FAIL arst_grant: got %h exp %h", grant, 8'h00); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b exp %b", gnt_valid, 1'b0); end
    n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL arst_sel: got %0d exp %0d", sel, 3'd0); end
    n_cmp++; if (owner_last !== 1'b0) begin n_err++; $display("FAIL arst_last: got %b exp %b", owner_last, 1'b0); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    beat  = 1'b0;
    test_reset();
    test_handoff();
    test_wrap();
    test_no_preempt();
    test_fairness();
`ifdef ARB_BURST_LIMIT_EN
    test_burst_limit();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
